// File: rtl/mvu_seq.sv
// Matrix-vector unit sequencer: walks precision x word x element steps for one job.
// Optional memory-side stall support is enabled by defining MVUSEQ_STALL_EN.
module mvu_seq #(
  parameter int BPREC    = 6,
  parameter int BWLENGTH = 8,
  parameter int BCNT     = 16,
  parameter int DRAIN    = 4
) (
  input  logic                clk,
  input  logic                clr,
  input  logic                start,
  input  logic [BPREC-1:0]    iprecision,
  input  logic [BPREC-1:0]    wprecision,
  input  logic [BWLENGTH-1:0] vlen,
  input  logic [BCNT-1:0]     nelem,
  input  logic                stall,
  output logic                agu_clr,
  output logic                agu_en,
  output logic                acc_clr,
  output logic                elem_last,
  output logic [BCNT-1:0]     elem_idx,
  output logic                busy,
  output logic                done
);

  localparam int PW = 2 * BPREC;
  localparam int DW = (DRAIN < 2) ? 1 : $clog2(DRAIN + 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_RUN   = 3'd2;
  localparam logic [2:0] S_DRAIN = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic [2:0]          state;
  logic [2:0]          state_nxt;
  logic [BPREC-1:0]    iprec_q;
  logic [BPREC-1:0]    wprec_q;
  logic [BWLENGTH-1:0] vlen_q;
  logic [BCNT-1:0]     nelem_q;
  logic [PW-1:0]       pprod_q;
  logic [PW-1:0]       prec_cnt;
  logic [BWLENGTH-1:0] word_cnt;
  logic [BCNT-1:0]     elem_cnt;
  logic [DW-1:0]       drain_cnt;

  logic hold;
  logic step;
  logic last_prec;
  logic last_word;
  logic last_elem;
  logic zero_job;
  logic drain_end;

  // Without stall support the input is deliberately left without effect.
`ifdef MVUSEQ_STALL_EN
  assign hold = stall;
`else
  logic stall_unused;
  assign stall_unused = stall;
  assign hold         = 1'b0;
`endif

  assign step      = (state == S_RUN) && !hold;
  assign last_prec = (prec_cnt == pprod_q - PW'(1));
  assign last_word = (word_cnt == vlen_q - BWLENGTH'(1));
  assign last_elem = (elem_cnt == nelem_q - BCNT'(1));
  assign zero_job  = (nelem_q == '0) || (vlen_q == '0) ||
                     (iprec_q == '0) || (wprec_q == '0);
  assign drain_end = (drain_cnt == DW'(DRAIN - 1));

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_LOAD;
      S_LOAD:  state_nxt = zero_job ? S_DONE : S_RUN;
      S_RUN:   if (step && last_prec && last_word && last_elem) state_nxt = S_DRAIN;
      S_DRAIN: if (drain_end) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Precision is the innermost loop, then words, then output elements.
  always_ff @(posedge clk) begin
    if (clr) begin
      state     <= S_IDLE;
      iprec_q   <= '0;
      wprec_q   <= '0;
      vlen_q    <= '0;
      nelem_q   <= '0;
      pprod_q   <= '0;
      prec_cnt  <= '0;
      word_cnt  <= '0;
      elem_cnt  <= '0;
      drain_cnt <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        S_IDLE: begin
          if (start) begin
            iprec_q <= iprecision;
            wprec_q <= wprecision;
            vlen_q  <= vlen;
            nelem_q <= nelem;
          end
        end
        S_LOAD: begin
          pprod_q   <= PW'(iprec_q) * PW'(wprec_q);
          prec_cnt  <= '0;
          word_cnt  <= '0;
          elem_cnt  <= '0;
          drain_cnt <= '0;
        end
        S_RUN: begin
          if (step) begin
            if (!last_prec) begin
              prec_cnt <= prec_cnt + PW'(1);
            end else begin
              prec_cnt <= '0;
              if (!last_word) begin
                word_cnt <= word_cnt + BWLENGTH'(1);
              end else begin
                word_cnt <= '0;
                elem_cnt <= last_elem ? '0 : elem_cnt + BCNT'(1);
              end
            end
          end
        end
        S_DRAIN: drain_cnt <= drain_cnt + DW'(1);
        S_DONE:  drain_cnt <= '0;
        default: drain_cnt <= '0;
      endcase
    end
  end

  assign agu_clr   = (state == S_LOAD);
  assign agu_en    = step;
  assign acc_clr   = step && (prec_cnt == '0) && (word_cnt == '0);
  assign elem_last = step && last_prec && last_word;
  assign elem_idx  = (state == S_RUN) ? elem_cnt : '0;
  assign busy      = (state != S_IDLE);
  assign done      = (state == S_DONE);

endmodule

// File: doc/mvu_seq.md
MVU_SEQ -- requirements
Module: mvu_seq

Interface
REQ-001 SHALL provide parameter BPREC, default 6, precision field width.
REQ-002 SHALL provide parameter BWLENGTH, default 8, vector-length field width.
REQ-003 SHALL provide parameter BCNT, default 16, element-count width.
REQ-004 SHALL provide parameter DRAIN, default 4, post-run pipeline drain cycles (>=1).
REQ-005 SHALL have port clk  input  1  clock; one clock, all logic on its rising edge.
REQ-006 SHALL have port clr  input  1  reset, synchronous, active-high.
REQ-007 SHALL have port start  input  1  job request pulse.
REQ-008 SHALL have port iprecision  input  BPREC  input data precision (bits).
REQ-009 SHALL have port wprecision  input  BPREC  weight precision (bits).
REQ-010 SHALL have port vlen  input  BWLENGTH  dot-product length per output element, in words.
REQ-011 SHALL have port nelem  input  BCNT  output elements per job.
REQ-012 SHALL have port stall  input  1  memory-side hold request.
REQ-013 SHALL have ports agu_clr and agu_en  output  1 each  clear/step to the address-generation datapath.
REQ-014 SHALL have ports acc_clr and elem_last  output  1 each  first/last step of each output element.
REQ-015 SHALL have port elem_idx  output  BCNT  index of element currently stepping.
REQ-016 SHALL have ports busy and done  output  1 each  job in progress / one-cycle completion pulse.

Function
REQ-017 SHALL implement states IDLE, LOAD, RUN, DRAIN, DONE.
REQ-018 SHALL, in IDLE with start=1, latch iprecision, wprecision, vlen, nelem and go to LOAD next cycle; start in any other state SHALL be ignored.
REQ-019 SHALL assert agu_clr=1 for exactly the single LOAD cycle, and compute pprod = iprecision*wprecision at 2*BPREC bits, no truncation.
REQ-020 SHALL go LOAD -> DONE (no agu_en) when latched nelem, vlen, iprecision or wprecision is zero; otherwise LOAD -> RUN.
REQ-021 SHALL, in RUN, drive agu_en = !stall; nested counters (precision step 0..pprod-1, word 0..vlen-1, element 0..nelem-1) advance only on agu_en cycles.
REQ-022 SHALL produce exactly nelem*vlen*pprod agu_en cycles per job.
REQ-023 SHALL assert acc_clr with agu_en on the first step (precision=0, word=0) of every element, and elem_last with agu_en on its last step.
REQ-024 SHALL drive elem_idx = element counter; 0 outside RUN.
REQ-025 SHALL go RUN -> DRAIN the cycle after the final agu_en; stall asserted on the final step cycle SHALL hold RUN until the step issues.
REQ-026 SHALL remain in DRAIN exactly DRAIN cycles, then DONE for one cycle with done=1, then IDLE.
REQ-027 SHALL hold busy=1 in LOAD, RUN, DRAIN, DONE; 0 in IDLE.
REQ-028 SHALL ignore stall outside RUN.

Reset
REQ-029 SHALL, on clr=1 at a clock edge in any state including mid-job, enter IDLE and zero all counters and latched fields.
REQ-030 SHALL drive agu_clr, agu_en, acc_clr, elem_last, busy, done =0 and elem_idx=0 during and after reset until a new start.
REQ-031 SHALL ignore start in the same cycle as clr=1.

Configuration
REQ-032 SHALL honour macro MVUSEQ_STALL_EN: defined -> stall behaves per REQ-021/REQ-025.
REQ-033 SHALL, with MVUSEQ_STALL_EN undefined, ignore stall entirely; agu_en=1 every RUN cycle, RUN lasts exactly nelem*vlen*pprod cycles.

Verification
REQ-034 SHALL verify: pw=2, pd=2, vlen=3, nelem=2, stall=0, start at cycle 0 -> agu_clr cycle 1, agu_en cycles 2-25 (24), acc_clr cycles 2,14, elem_last cycles 13,25, done cycle 30 (DRAIN=4).
REQ-035 SHALL verify: same job, stall=1 cycles 5-7 (STALL_EN defined) -> agu_en low cycles 5-7, 24 steps total, done at cycle 33.
REQ-036 SHALL verify: nelem=0, start at cycle 0 -> agu_clr cycle 1, no agu_en, done cycle 2, busy low cycle 3.
REQ-037 SHALL verify: pw=1, pd=1, vlen=1, nelem=1 -> single agu_en cycle 2 with acc_clr=elem_last=1, done cycle 7.
REQ-038 SHALL verify: clr=1 at cycle 10 mid-RUN -> all outputs 0 from cycle 11; new start cycle 12 runs full job correctly.
REQ-039 SHALL verify: start pulses during RUN and during DONE -> ignored; exactly one done per accepted job.
